mult_seq_ctrl: RTL and testbench

//  Sequencing controller for the shared 16-bit adder (select_adder/adder_4 datapath): performs a

---
 rtl/mult_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_mult_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl
//   Sequencing controller for a shared external adder. Performs a
//   WIDTH x WIDTH shift-add multiply, driving the adder once per cycle and
//   accumulating its sum. The adder inputs are only driven while running;
//   at all other times they are zero so the adder can be muxed to other users.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_valid  request to multiply op_a * op_b
//   start_ready  high only in IDLE
//   signed_mode  sampled on accept: 1 = two's complement, 0 = unsigned
//   op_a, op_b   multiplicand / multiplier, sampled on accept
//   abort        synchronous cancel back to IDLE, no result produced
//   busy         high in RUN and DONE
//   res_valid    product valid (DONE)
//   res_ready    consumer accepts the product
//   product      2*WIDTH-bit result, stable while res_valid
//   add_a/add_b  adder operands (accumulator / shifted multiplicand term)
//   add_cin      adder carry-in (1 only on the signed MSB subtract step)
//   add_s        adder sum; only the low 2*WIDTH bits are used
//   add_cout     adder carry-out; unused (result is modulo 2^(2*WIDTH))

module mult_seq_ctrl #(
  parameter int WIDTH   = 8,
  parameter int ADDER_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic                 abort,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [ADDER_W-1:0]   add_a,
  output logic [ADDER_W-1:0]   add_b,
  output logic                 add_cin,
  input  logic [ADDER_W-1:0]   add_s,
  input  logic                 add_cout
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  generate
    if (PW > ADDER_W) begin : g_width_check
      $error("mult_seq_ctrl: 2*WIDTH exceeds ADDER_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] q_reg;
  logic             sgn_reg;
  logic [PW-1:0]    acc_reg;
  logic [PW-1:0]    product_reg;
  logic [CW-1:0]    i_reg;

  logic             accept;
  logic             last_iter;
  logic             q_bit;
  logic [WIDTH-1:0] q_shifted;
  logic [PW-1:0]    mx;
  logic [PW-1:0]    m_term;
  logic [PW-1:0]    sum_low;

  // Carry-out and any adder bits above the product width are intentionally
  // ignored; fold them into one named sink.
  logic unused_adder_bits;
  generate
    if (ADDER_W > PW) begin : g_upper
      assign unused_adder_bits = ^{add_cout, add_s[ADDER_W-1:PW]};
    end else begin : g_no_upper
      assign unused_adder_bits = add_cout;
    end
  endgenerate

  assign sum_low     = add_s[PW-1:0];
  assign accept      = (state_reg == S_IDLE) && start_valid && !abort;
  assign last_iter   = (i_reg == CW'(WIDTH - 1));
  assign q_shifted   = q_reg >> i_reg;
  assign q_bit       = q_shifted[0];
  assign mx          = sgn_reg ? {{WIDTH{m_reg[WIDTH-1]}}, m_reg}
                               : {{WIDTH{1'b0}}, m_reg};
  assign m_term      = mx << i_reg;

  assign start_ready = (state_reg == S_IDLE);
  assign busy        = (state_reg == S_RUN) || (state_reg == S_DONE);
  assign res_valid   = (state_reg == S_DONE);
  assign product     = product_reg;

  // Next state and adder drive. The MSB of a two's-complement multiplier has
  // negative weight, so that step subtracts: acc + ~term + 1.
  always_comb begin
    state_next = state_reg;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept) state_next = S_RUN;
      end
      S_RUN: begin
        add_a = ADDER_W'(acc_reg);
        if (q_bit) begin
          if (sgn_reg && last_iter) begin
            add_b   = ADDER_W'(~m_term);
            add_cin = 1'b1;
          end else begin
            add_b = ADDER_W'(m_term);
          end
        end
        if (abort)          state_next = S_IDLE;
        else if (last_iter) state_next = S_DONE;
      end
      S_DONE: begin
        if (abort || res_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      m_reg       <= '0;
      q_reg       <= '0;
      sgn_reg     <= 1'b0;
      acc_reg     <= '0;
      product_reg <= '0;
      i_reg       <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        m_reg   <= op_a;
        q_reg   <= op_b;
        sgn_reg <= signed_mode;
        acc_reg <= '0;
        i_reg   <= '0;
      end else if (state_reg == S_RUN && !abort) begin
        acc_reg <= sum_low;
        i_reg   <= i_reg + CW'(1);
        if (last_iter) product_reg <= sum_low;
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl
//   Self-checking bench for mult_seq_ctrl with a behavioural 16-bit adder
//   attached. Expected products are computed from the operands when each
//   request is driven, queued, and compared when the result handshake occurs.

module tb_mult_seq_ctrl;

  localparam int WIDTH   = 8;
  localparam int ADDER_W = 16;
  localparam int PW      = 2 * WIDTH;

  logic                clk;
  logic                rst_n;
  logic                start_valid;
  logic                start_ready;
  logic                signed_mode;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic                abort;
  logic                busy;
  logic                res_valid;
  logic                res_ready;
  logic [PW-1:0]       product;
  logic [ADDER_W-1:0]  add_a;
  logic [ADDER_W-1:0]  add_b;
  logic                add_cin;
  logic [ADDER_W-1:0]  add_s;
  logic                add_cout;

  int checks   = 0;
  int failures = 0;

  logic [PW-1:0] exp_q[$];

  mult_seq_ctrl #(.WIDTH(WIDTH), .ADDER_W(ADDER_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .signed_mode (signed_mode),
    .op_a        (op_a),
    .op_b        (op_b),
    .abort       (abort),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .product     (product),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_cin     (add_cin),
    .add_s       (add_s),
    .add_cout    (add_cout)
  );

  // External adder: plain combinational sum with carry-out.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{ADDER_W{1'b0}}, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] model_prod(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic s);
    logic signed [PW-1:0] sa, sb;
    logic [PW-1:0] ua, ub;
    if (s) begin
      sa = PW'($signed(a));
      sb = PW'($signed(b));
      return PW'(sa * sb);
    end
    ua = PW'(a);
    ub = PW'(b);
    return PW'(ua * ub);
  endfunction

  // One complete multiply: accept, count latency and carry-in cycles, hold
  // the result for 'hold' cycles with res_ready low, then hand it off.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic s, input int hold,
                        input int exp_cin_cnt);
    int cycles;
    int cin_cnt;
    int cin_at;
    int busy_low;
    logic [PW-1:0] held;
    logic [PW-1:0] exp_p;
    @(negedge clk);
    check({tag, " start_ready idle"}, 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    op_a        = a;
    op_b        = b;
    signed_mode = s;
    exp_q.push_back(model_prod(a, b, s));
    @(posedge clk); #1;
    start_valid = 1'b0;
    cycles   = 0;
    cin_cnt  = 0;
    cin_at   = -1;
    busy_low = 0;
    while (!res_valid && cycles < 20) begin
      if (!busy) busy_low++;
      if (add_cin) begin
        cin_cnt++;
        cin_at = cycles;
      end
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, " latency"}, 32'(cycles), 32'd8);
    check({tag, " busy during run"}, 32'(busy_low), 32'd0);
    check({tag, " cin count"}, 32'(cin_cnt), 32'(exp_cin_cnt));
    if (exp_cin_cnt > 0) check({tag, " cin iteration"}, 32'(cin_at), 32'd7);
    held = product;
    res_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      start_valid = 1'b1;
      op_a        = 8'h01;
      op_b        = 8'h01;
      signed_mode = 1'b0;
      @(posedge clk); #1;
      check({tag, " hold valid"}, 32'(res_valid), 32'd1);
      check({tag, " hold product"}, 32'(product), 32'(held));
      check({tag, " hold start_ready"}, 32'(start_ready), 32'd0);
      check({tag, " hold adder idle"}, 32'({add_a, add_b, add_cin}), 32'd0);
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    if (exp_q.size() > 0) exp_p = exp_q.pop_front();
    else exp_p = '0;
    check({tag, " product"}, 32'(product), 32'(exp_p));
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, " valid after handshake"}, 32'(res_valid), 32'd0);
    check({tag, " busy after handshake"}, 32'(busy), 32'd0);
    check({tag, " start_ready after handshake"}, 32'(start_ready), 32'd1);
    $display("op %s: a=0x%02h b=0x%02h signed=%0d product=0x%04h latency=%0d", tag, a, b, s, product, cycles);
  endtask

  initial begin
    logic [PW-1:0] prev_prod;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    signed_mode = 1'b0;
    op_a        = '0;
    op_b        = '0;
    abort       = 1'b0;
    res_ready   = 1'b0;
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset product", 32'(product), 32'd0);
    check("reset adder", 32'({add_a, add_b, add_cin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset start_ready", 32'(start_ready), 32'd1);

    run_op("u13x11",   8'd13,  8'd11,  1'b0, 0, 0);
    run_op("s-3x5",    8'hFD,  8'h05,  1'b1, 0, 0);
    run_op("s-128sq",  8'h80,  8'h80,  1'b1, 0, 1);
    run_op("u255sq",   8'hFF,  8'hFF,  1'b0, 0, 0);
    run_op("s255sq",   8'hFF,  8'hFF,  1'b1, 5, 1);

    // Abort part-way through iteration 3.
    prev_prod = product;
    @(negedge clk);
    start_valid = 1'b1;
    op_a = 8'h55; op_b = 8'h33; signed_mode = 1'b0;
    @(posedge clk); #1;
    start_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort start_ready", 32'(start_ready), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("abort no valid", 32'(res_valid), 32'd0);
    end
    check("abort product kept", 32'(product), 32'(prev_prod));
    $display("op abort: a=0x55 b=0x33 cancelled, product=0x%04h", product);

    // Abort in IDLE wins over start_valid.
    @(negedge clk);
    start_valid = 1'b1;
    abort       = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    abort       = 1'b0;
    check("idle abort no accept", 32'(busy), 32'd0);

    run_op("u7x9",     8'd7,   8'd9,   1'b0, 0, 0);

    // Asynchronous reset between edges in the middle of a run.
    @(negedge clk);
    start_valid = 1'b1;
    op_a = 8'h12; op_b = 8'h34; signed_mode = 1'b0;
    @(posedge clk); #1;
    start_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    check("pre-reset busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset product", 32'(product), 32'd0);
    check("async reset adder", 32'({add_a, add_b, add_cin}), 32'd0);
    check("async reset valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("op reset: mid-run reset applied");

    run_op("u2x3",     8'd2,   8'd3,   1'b0, 0, 0);
    run_op("sneg",     8'h9C,  8'h07,  1'b1, 2, 0);

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
